// File: rtl/dtr_pkg.sv
// Shared types for the DTR recovery sequencer: state encoding and Moore output decode.
package dtr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORMAL,
        ROLLBACK,
        RECOVER,
        FAULT
    } state_t;

    // Bit order: save, rollBack, out_valid, busy, fault
    typedef struct packed {
        logic save;
        logic rollback;
        logic out_valid;
        logic busy;
        logic fault;
    } out_dec_t;

    localparam out_dec_t OUT_IDLE     = 5'b00000;
    localparam out_dec_t OUT_NORMAL   = 5'b10100;
    localparam out_dec_t OUT_ROLLBACK = 5'b01010;
    localparam out_dec_t OUT_RECOVER  = 5'b10010;
    localparam out_dec_t OUT_FAULT    = 5'b01001;

    function automatic out_dec_t decode_outputs(input state_t s);
        case (s)
            NORMAL:   return OUT_NORMAL;
            ROLLBACK: return OUT_ROLLBACK;
            RECOVER:  return OUT_RECOVER;
            FAULT:    return OUT_FAULT;
            default:  return OUT_IDLE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dtr_recovery_ctrl_if.sv
// Control/status bundle between the recovery sequencer and its environment.
interface dtr_recovery_ctrl_if #(
    parameter int N_FF  = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic [N_FF-1:0]  fail_i;
    logic             save;
    logic             rollBack;
    logic             out_valid;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, clr, fail_i,
        input  save, rollBack, out_valid, busy, fault, err_cnt
    );

    modport slave (
        input  en, clr, fail_i,
        output save, rollBack, out_valid, busy, fault, err_cnt
    );
endinterface

// File: rtl/dtr_down_counter.sv
// Loadable down counter that stops at zero and flags it.
module dtr_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/dtr_recovery_ctrl.sv
// Sequencer for time-double-redundant cells: rollback, replay, resume, escalate on recurring errors.
module dtr_recovery_ctrl
    import dtr_pkg::*;
#(
    parameter int N_FF         = 8,
    parameter int ROLLBACK_CYC = 2,
    parameter int RECOVER_CYC  = 3,
    parameter int RETRY_WINDOW = 16,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dtr_recovery_ctrl_if.slave bus
);
    localparam int CW = $clog2(max3(ROLLBACK_CYC, RECOVER_CYC, RETRY_WINDOW)) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t           state_q, state_d;
    logic [RW-1:0]    retry_q, retry_d, retry_step;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fail_any, take_fail, err_inc;
    logic             cyc_load, cyc_dec, cyc_zero;
    logic             win_load, win_dec, win_zero;
    logic [CW-1:0]    cyc_val, win_val;
    out_dec_t         outs;

    assign fail_any = |bus.fail_i;

    dtr_down_counter #(.W(CW)) u_cyc_cnt (
        .clk(clk), .rst_n(rst_n), .load(cyc_load), .load_val(cyc_val),
        .dec(cyc_dec), .zero(cyc_zero)
    );

    dtr_down_counter #(.W(CW)) u_win_cnt (
        .clk(clk), .rst_n(rst_n), .load(win_load), .load_val(win_val),
        .dec(win_dec), .zero(win_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            retry_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_step = RW'(1);
        take_fail  = 1'b0;
        err_inc    = 1'b0;
        cyc_load   = 1'b0;
        cyc_val    = '0;
        cyc_dec    = 1'b0;
        win_load   = 1'b0;
        win_val    = '0;
        win_dec    = 1'b0;

        case (state_q)
            IDLE: if (bus.en) state_d = NORMAL;
            NORMAL: begin
                if (fail_any) begin
                    take_fail  = 1'b1;
                    retry_step = win_zero ? RW'(1) : RW'(retry_q + 1'b1);
                end else begin
                    if (!bus.en) state_d = IDLE;
                    // Window expiry ends the retry streak; clearing one cycle late is harmless
                    // because a fail seen with the window at zero restarts the streak at 1.
                    if (win_zero) retry_d = '0;
                    else          win_dec = 1'b1;
                end
            end
            ROLLBACK: begin
                if (cyc_zero) begin
                    state_d  = RECOVER;
                    cyc_load = 1'b1;
                    cyc_val  = CW'(RECOVER_CYC - 1);
                end else begin
                    cyc_dec = 1'b1;
                end
            end
            RECOVER: begin
                if (fail_any) begin
                    take_fail  = 1'b1;
                    retry_step = RW'(retry_q + 1'b1);
                end else if (cyc_zero) begin
                    state_d  = NORMAL;
                    win_load = 1'b1;
                    win_val  = CW'(RETRY_WINDOW);
                end else begin
                    cyc_dec = 1'b1;
                end
            end
            FAULT: begin
                if (bus.clr) begin
                    state_d = IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_fail) begin
            err_inc = 1'b1;
            retry_d = retry_step;
            if (int'(retry_step) == MAX_RETRY) begin
                state_d = FAULT;
            end else begin
                state_d  = ROLLBACK;
                cyc_load = 1'b1;
                cyc_val  = CW'(ROLLBACK_CYC - 1);
            end
        end

        if (state_d == IDLE) begin
            win_load = 1'b1;
            win_val  = '0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr)
            err_cnt_d = '0;
        else if (err_inc && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_comb begin
        outs          = decode_outputs(state_q);
        bus.save      = outs.save;
        bus.rollBack  = outs.rollback;
        bus.out_valid = outs.out_valid;
        bus.busy      = outs.busy;
        bus.fault     = outs.fault;
        bus.err_cnt   = err_cnt_q;
    end
endmodule

// File: doc/dtr_recovery_ctrl.md
Name: dtr_recovery_ctrl

Overview:
- Central sequencer for a bank of time-double-redundant flip-flop cells. Each cell exposes save, rollBack and fail.
- Watches the OR of all cell fail flags and drives shared save/rollBack to the cells.
- On error: freezes the image registers, rolls the cells back, replays, and resumes.
- Escalates to a sticky fault state when errors recur faster than the retry window allows.

Parameters:
- N_FF, 8, number of protected cells (width of fail_i)
- ROLLBACK_CYC, 2, cycles rollBack held high per recovery (>=1)
- RECOVER_CYC, 3, replay cycles with save=1 before resuming normal output (>=1)
- RETRY_WINDOW, 16, cycles after resuming during which a new fail counts as a retry (>=1)
- MAX_RETRY, 3, consecutive retries that escalate to FAULT (>=1)
- CNT_W, 8, width of the error event counter

Ports:
- clk, in, 1, system clock, all logic on rising edge
- rst_n, in, 1, synchronous active-low reset
- en, in, 1, enable protection sequencing
- clr, in, 1, one-cycle pulse: leave FAULT, clear err_cnt
- fail_i, in, N_FF, per-cell error flags
- save, out, 1, broadcast to cells: image registers capture
- rollBack, out, 1, broadcast to cells: outputs taken from the saved image
- out_valid, out, 1, primary outputs of the protected circuit are trustworthy
- busy, out, 1, recovery in progress (ROLLBACK or RECOVER)
- fault, out, 1, sticky: recovery gave up
- err_cnt, out, CNT_W, number of rollback entries, saturating

Behaviour:
- Outputs are Moore-decoded from the state register. err_cnt is a register.
- fail_any = |fail_i, sampled at each rising edge.

Reset (rst_n=0 at an edge):
- State becomes IDLE; retry count, cycle counter and window counter go to 0; err_cnt=0.
- Outputs: save=0, rollBack=0, out_valid=0, busy=0, fault=0.
- Reset mid-recovery aborts immediately; there is no partial completion.

States, with outputs (save, rollBack, out_valid, busy, fault):
- IDLE (0,0,0,0,0): en=1 -> NORMAL.
- NORMAL (1,0,1,0,0):
  - fail_any=1 -> ROLLBACK. This takes priority over en=0.
  - en=0 and fail_any=0 -> IDLE.
  - The one save=1 cycle after the fault is seen is accepted by design; the two-deep image pipeline covers it.
- ROLLBACK (0,1,0,1,0):
  - Held exactly ROLLBACK_CYC cycles, then -> RECOVER.
  - fail_i and en are ignored.
- RECOVER (1,0,0,1,0):
  - Held RECOVER_CYC cycles, then -> NORMAL with the window counter loaded to RETRY_WINDOW.
  - fail_any=1 in any RECOVER cycle counts as a retry and goes to ROLLBACK (or FAULT, see retry rules). The cycle counter restarts.
- FAULT (0,1,0,0,1):
  - Image held frozen.
  - Exits only via clr=1 -> IDLE (err_cnt cleared, retry count cleared) or via reset.

Entry into ROLLBACK:
- err_cnt increments, saturating at 2^CNT_W-1.
- The retry count increments if the entry comes from RECOVER, or from NORMAL while the window counter is non-zero. Otherwise the retry count is set to 1.

Retry rules:
- If the incremented retry count would equal MAX_RETRY, go to FAULT instead of ROLLBACK. err_cnt still increments.
- In NORMAL the window counter decrements to 0. When it reaches 0, the retry count clears.
- Simultaneous fail_any and window reaching 0: the fail counts as a retry (window still non-zero at sampling).

Other rules:
- clr outside FAULT clears err_cnt only. If clr coincides with an increment, clr wins.
- Cycle-counter width is $clog2 of the max of ROLLBACK_CYC, RECOVER_CYC and RETRY_WINDOW, plus 1. No wrap is possible.

Decomposition:
- dtr_pkg holds the state enum (IDLE, NORMAL, ROLLBACK, RECOVER, FAULT) and the output-decode constants for each state.
- One sub-module, dtr_down_counter: loadable down counter with a zero flag. It is instantiated twice, once as the phase cycle counter and once as the retry window counter.
- Saturating err_cnt stays inline.

Test Plan:
- Reset then en=1: IDLE one cycle, then NORMAL; save=1, out_valid=1, err_cnt=0.
- Single fail_i=8'h04 pulse in NORMAL: next 2 cycles rollBack=1, save=0; next 3 cycles save=1, out_valid=0; then NORMAL; err_cnt=1; fault=0.
- Fail during the 2nd RECOVER cycle: new ROLLBACK starts next edge, err_cnt=2, retry count=2. A third fail inside the window gives FAULT with fault=1, rollBack=1, err_cnt=3.
- Fail 17 cycles after resuming (window 16 expired): normal recovery, retry count back to 1, no FAULT even after 10 such spaced errors; err_cnt=10.
- In FAULT, pulse clr: IDLE next cycle, err_cnt=0, fault=0. With en held at 1, NORMAL the cycle after.
- rst_n=0 during ROLLBACK: all outputs 0 next edge. With CNT_W=2 and 5 spaced errors, err_cnt saturates at 3.
